// File: rtl/vsim_send_arbiter.sv
// Round-robin arbiter that multiplexes whole messages from NREQ sources onto one beat port.
// Optional feature: define VSIM_SEND_ARB_HEADER_EN to prefix each message with a header beat carrying grant_id.
module vsim_send_arbiter #(
  parameter int width = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       pend,
  input  logic [NREQ-1:0]       EN_req,
  output logic [NREQ-1:0]       RDY_req,
  input  logic [NREQ*width-1:0] req_v,
  input  logic [NREQ-1:0]       req_last,
  output logic                  EN_beat,
  input  logic                  RDY_beat,
  output logic [width-1:0]      beat_v,
  output logic                  beat_last,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

`ifdef VSIM_SEND_ARB_HEADER_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_BODY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BODY = 2'd2} state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic             r_busy;
  logic             r_obuf_valid;
  logic [width-1:0] r_obuf_data;
  logic             r_obuf_last;

  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_rr_next;
  logic             w_obuf_free;
  logic             w_accept;
  logic             w_last_acc;
  logic             w_ld_body;
  logic             w_ld_hdr;
  logic [width-1:0] w_req_data;

  assign w_obuf_free = !r_obuf_valid || RDY_beat;
  assign w_accept    = (r_state == S_BODY) && w_obuf_free && EN_req[r_grant_id];
  assign w_last_acc  = w_accept && req_last[r_grant_id];
  assign w_req_data  = req_v[int'(r_grant_id)*width +: width];
  assign w_rr_next   = (r_grant_id == IDW'(NREQ-1)) ? '0 : r_grant_id + 1'b1;

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic found;
    found  = 1'b0;
    w_pick = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && pend[(int'(r_rr_ptr) + k) % NREQ]) begin
        found  = 1'b1;
        w_pick = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|pend) begin
`ifdef VSIM_SEND_ARB_HEADER_EN
          w_state_next = S_HDR;
`else
          w_state_next = S_BODY;
`endif
        end
      end
`ifdef VSIM_SEND_ARB_HEADER_EN
      S_HDR:  if (w_obuf_free) w_state_next = S_BODY;
`endif
      S_BODY: if (w_last_acc) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld_body = w_accept;
`ifdef VSIM_SEND_ARB_HEADER_EN
    w_ld_hdr  = (r_state == S_HDR) && w_obuf_free;
`else
    w_ld_hdr  = 1'b0;
`endif
    RDY_req = '0;
    for (int n = 0; n < NREQ; n++) begin
      RDY_req[n] = (r_state == S_BODY) && (r_grant_id == IDW'(n)) && w_obuf_free;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_busy       <= 1'b0;
      r_obuf_valid <= 1'b0;
      r_obuf_data  <= '0;
      r_obuf_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && |pend) r_grant_id <= w_pick;
      if (w_last_acc) r_rr_ptr <= w_rr_next;
      // Outside IDLE a message is in flight; in IDLE busy tracks the draining last beat.
      if (r_state == S_IDLE) r_busy <= (|pend) || (r_obuf_valid && !RDY_beat);
      if (w_ld_body) begin
        r_obuf_data  <= w_req_data;
        r_obuf_last  <= req_last[r_grant_id];
        r_obuf_valid <= 1'b1;
      end else if (w_ld_hdr) begin
        r_obuf_data  <= width'(r_grant_id);
        r_obuf_last  <= 1'b0;
        r_obuf_valid <= 1'b1;
      end else if (EN_beat) begin
        r_obuf_valid <= 1'b0;
      end
    end
  end

  assign EN_beat   = r_obuf_valid && RDY_beat;
  assign beat_v    = r_obuf_data;
  assign beat_last = r_obuf_last;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;

endmodule
